// File: rtl/bu_rsp_tx_if.sv
// Channel bundles for the buffer-unit retire transmitter: retire register -> bu_rsp_tx,
// and bu_rsp_tx -> NOU response port.
`ifndef NOU_SID_WIDTH
`define NOU_SID_WIDTH 4
`endif
`ifndef NOU_RSP_TYPE_ID_WIDTH
`define NOU_RSP_TYPE_ID_WIDTH 2
`endif
`ifndef NOU_BUF_ID_WIDTH
`define NOU_BUF_ID_WIDTH 4
`endif
`ifndef NOU_ERR_CODE_WIDTH
`define NOU_ERR_CODE_WIDTH 4
`endif
`ifndef NOU_BUF_RM_WIDTH
`define NOU_BUF_RM_WIDTH 2
`endif

interface bu_retire_if;
    logic                                retire_vld;
    logic [`NOU_SID_WIDTH-1:0]           sid;
    logic [`NOU_RSP_TYPE_ID_WIDTH-1:0]   rtype;
    logic [`NOU_BUF_ID_WIDTH-1:0]        buf_id;
    logic                                status;
    logic [`NOU_ERR_CODE_WIDTH-1:0]      err_code;
    logic [`NOU_BUF_RM_WIDTH-1:0]        rm;
    logic                                retire_keep;

    modport master (
        output retire_vld, sid, rtype, buf_id, status, err_code, rm,
        input  retire_keep
    );
    modport slave (
        input  retire_vld, sid, rtype, buf_id, status, err_code, rm,
        output retire_keep
    );
endinterface

interface bu_rsp_if;
    logic                                rsp_vld;
    logic                                rsp_rdy;
    logic [`NOU_SID_WIDTH-1:0]           rsp_sid;
    logic [`NOU_RSP_TYPE_ID_WIDTH-1:0]   rsp_rtype;
    logic [`NOU_BUF_ID_WIDTH-1:0]        rsp_buf_id;
    logic                                rsp_status;
    logic [`NOU_ERR_CODE_WIDTH-1:0]      rsp_err_code;

    modport master (
        output rsp_vld, rsp_sid, rsp_rtype, rsp_buf_id, rsp_status, rsp_err_code,
        input  rsp_rdy
    );
    modport slave (
        input  rsp_vld, rsp_sid, rsp_rtype, rsp_buf_id, rsp_status, rsp_err_code,
        output rsp_rdy
    );
endinterface

// File: rtl/bu_rsp_tx.sv
// Retire-to-response transmitter: small FIFO between the retire register and the NOU
// response channel, plus buffer-release pulses and a saturating error-response counter.
`ifndef NOU_SID_WIDTH
`define NOU_SID_WIDTH 4
`endif
`ifndef NOU_RSP_TYPE_ID_WIDTH
`define NOU_RSP_TYPE_ID_WIDTH 2
`endif
`ifndef NOU_BUF_ID_WIDTH
`define NOU_BUF_ID_WIDTH 4
`endif
`ifndef NOU_ERR_CODE_WIDTH
`define NOU_ERR_CODE_WIDTH 4
`endif
`ifndef NOU_BUF_RM_WIDTH
`define NOU_BUF_RM_WIDTH 2
`endif

module bu_rsp_tx #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    bu_retire_if.slave                    retire,
    bu_rsp_if.master                      rsp,
    output logic                          buf_rel_vld,
    output logic [`NOU_BUF_ID_WIDTH-1:0]  buf_rel_id,
    input  logic                          err_cnt_clr,
    output logic [CNT_W-1:0]              err_cnt,
    output logic                          idle
);

    localparam int              PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]  C_FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    typedef struct packed {
        logic [`NOU_SID_WIDTH-1:0]         sid;
        logic [`NOU_RSP_TYPE_ID_WIDTH-1:0] rtype;
        logic [`NOU_BUF_ID_WIDTH-1:0]      buf_id;
        logic                              status;
        logic [`NOU_ERR_CODE_WIDTH-1:0]    err_code;
        logic [`NOU_BUF_RM_WIDTH-1:0]      rm;
    } entry_t;

    entry_t                          r_mem [DEPTH];
    logic [PTR_W-1:0]                r_wr_ptr;
    logic [PTR_W-1:0]                r_rd_ptr;
    logic [PTR_W:0]                  r_count;
    logic                            r_buf_rel_vld;
    logic [`NOU_BUF_ID_WIDTH-1:0]    r_buf_rel_id;
    logic [CNT_W-1:0]                r_err_cnt;

    entry_t                          w_wr_entry;
    entry_t                          w_rd_entry;
    logic                            w_full;
    logic                            w_empty;
    logic                            w_push;
    logic                            w_pop;
    logic                            w_rel_hit;
    logic                            w_err_hit;

    // Full is taken from the registered count only, so rsp_rdy never reaches retire_keep.
    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = retire.retire_vld && !w_full;
    assign w_pop   = !w_empty && rsp.rsp_rdy;

    assign w_wr_entry.sid      = retire.sid;
    assign w_wr_entry.rtype    = retire.rtype;
    assign w_wr_entry.buf_id   = retire.buf_id;
    assign w_wr_entry.status   = retire.status;
    assign w_wr_entry.err_code = retire.err_code;
    assign w_wr_entry.rm       = retire.rm;

    assign w_rd_entry = r_mem[r_rd_ptr];
    assign w_rel_hit  = w_pop && (w_rd_entry.rm == '0);
    assign w_err_hit  = w_pop && !w_rd_entry.status;

    // Payload storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_buf_rel_vld <= 1'b0;
            r_buf_rel_id  <= '0;
        end else begin
            r_buf_rel_vld <= w_rel_hit;
            if (w_rel_hit) begin
                r_buf_rel_id <= w_rd_entry.buf_id;
            end
        end
    end

    // Clear wins over a same-cycle error pop; that pop is deliberately not counted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_cnt <= '0;
        end else if (err_cnt_clr) begin
            r_err_cnt <= '0;
        end else if (w_err_hit && (r_err_cnt != C_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign retire.retire_keep = w_full;

    assign rsp.rsp_vld      = !w_empty;
    assign rsp.rsp_sid      = w_rd_entry.sid;
    assign rsp.rsp_rtype    = w_rd_entry.rtype;
    assign rsp.rsp_buf_id   = w_rd_entry.buf_id;
    assign rsp.rsp_status   = w_rd_entry.status;
    assign rsp.rsp_err_code = w_rd_entry.err_code;

    assign buf_rel_vld = r_buf_rel_vld;
    assign buf_rel_id  = r_buf_rel_id;
    assign err_cnt     = r_err_cnt;
    assign idle        = w_empty && !r_buf_rel_vld;

endmodule

// File: tb/tb_bu_rsp_tx.sv
// Directed bench for bu_rsp_tx (DEPTH=2, CNT_W=4): ordering, back-pressure, release
// filtering, error-counter saturation/clear and mid-stream reset.
`ifndef NOU_SID_WIDTH
`define NOU_SID_WIDTH 4
`endif
`ifndef NOU_RSP_TYPE_ID_WIDTH
`define NOU_RSP_TYPE_ID_WIDTH 2
`endif
`ifndef NOU_BUF_ID_WIDTH
`define NOU_BUF_ID_WIDTH 4
`endif
`ifndef NOU_ERR_CODE_WIDTH
`define NOU_ERR_CODE_WIDTH 4
`endif
`ifndef NOU_BUF_RM_WIDTH
`define NOU_BUF_RM_WIDTH 2
`endif

module tb_bu_rsp_tx;

    logic                          clk;
    logic                          rstn;
    logic                          buf_rel_vld;
    logic [`NOU_BUF_ID_WIDTH-1:0]  buf_rel_id;
    logic                          err_cnt_clr;
    logic [3:0]                    err_cnt;
    logic                          idle;

    int checks = 0;
    int errors = 0;

    bu_retire_if rif();
    bu_rsp_if    sif();

    bu_rsp_tx #(.DEPTH(2), .CNT_W(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .retire      (rif),
        .rsp         (sif),
        .buf_rel_vld (buf_rel_vld),
        .buf_rel_id  (buf_rel_id),
        .err_cnt_clr (err_cnt_clr),
        .err_cnt     (err_cnt),
        .idle        (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int s, input int t, input int b,
                         input logic st, input int ec, input int r);
        rif.retire_vld = v;
        rif.sid        = s[`NOU_SID_WIDTH-1:0];
        rif.rtype      = t[`NOU_RSP_TYPE_ID_WIDTH-1:0];
        rif.buf_id     = b[`NOU_BUF_ID_WIDTH-1:0];
        rif.status     = st;
        rif.err_code   = ec[`NOU_ERR_CODE_WIDTH-1:0];
        rif.rm         = r[`NOU_BUF_RM_WIDTH-1:0];
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        checks++; if (sif.rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_rsp_vld: got %0b exp 0", sif.rsp_vld); end
        checks++; if (rif.retire_keep !== 1'b0) begin errors++; $display("FAIL reset_keep: got %0b exp 0", rif.retire_keep); end
        checks++; if (buf_rel_vld !== 1'b0) begin errors++; $display("FAIL reset_rel_vld: got %0b exp 0", buf_rel_vld); end
        checks++; if (buf_rel_id !== 4'd0) begin errors++; $display("FAIL reset_rel_id: got %0d exp 0", buf_rel_id); end
        checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d exp 0", err_cnt); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %0b exp 1", idle); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        sif.rsp_rdy = 1'b1;
        drive(1'b1, 3, 1, 5, 1'b1, 0, 0);
        tick();
        drive(1'b0, 0, 0, 0, 1'b1, 0, 1);
        checks++; if (sif.rsp_vld !== 1'b1) begin errors++; $display("FAIL single_vld: got %0b exp 1", sif.rsp_vld); end
        checks++; if (sif.rsp_sid !== 4'd3) begin errors++; $display("FAIL single_sid: got %0d exp 3", sif.rsp_sid); end
        checks++; if (sif.rsp_buf_id !== 4'd5) begin errors++; $display("FAIL single_buf_id: got %0d exp 5", sif.rsp_buf_id); end
        checks++; if (sif.rsp_rtype !== 2'd1) begin errors++; $display("FAIL single_rtype: got %0d exp 1", sif.rsp_rtype); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %0b exp 0", idle); end
        tick();
        checks++; if (buf_rel_vld !== 1'b1) begin errors++; $display("FAIL single_rel_vld: got %0b exp 1", buf_rel_vld); end
        checks++; if (buf_rel_id !== 4'd5) begin errors++; $display("FAIL single_rel_id: got %0d exp 5", buf_rel_id); end
        checks++; if (sif.rsp_vld !== 1'b0) begin errors++; $display("FAIL single_vld_after: got %0b exp 0", sif.rsp_vld); end
        tick();
        checks++; if (buf_rel_vld !== 1'b0) begin errors++; $display("FAIL single_rel_once: got %0b exp 0", buf_rel_vld); end
        checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL single_err_cnt: got %0d exp 0", err_cnt); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %0b exp 1", idle); end
    endtask

    task automatic test_back_pressure();
        sif.rsp_rdy = 1'b0;
        drive(1'b1, 1, 0, 1, 1'b1, 0, 1);
        tick();
        checks++; if (rif.retire_keep !== 1'b0) begin errors++; $display("FAIL bp_keep_1: got %0b exp 0", rif.retire_keep); end
        drive(1'b1, 2, 0, 2, 1'b1, 0, 1);
        tick();
        checks++; if (rif.retire_keep !== 1'b1) begin errors++; $display("FAIL bp_keep_2: got %0b exp 1", rif.retire_keep); end
        drive(1'b1, 3, 0, 3, 1'b1, 0, 1);
        tick();
        checks++; if (rif.retire_keep !== 1'b1) begin errors++; $display("FAIL bp_keep_held: got %0b exp 1", rif.retire_keep); end
        checks++; if (sif.rsp_sid !== 4'd1) begin errors++; $display("FAIL bp_order_1: got %0d exp 1", sif.rsp_sid); end
        sif.rsp_rdy = 1'b1;
        tick();
        checks++; if (sif.rsp_sid !== 4'd2) begin errors++; $display("FAIL bp_order_2: got %0d exp 2", sif.rsp_sid); end
        checks++; if (rif.retire_keep !== 1'b0) begin errors++; $display("FAIL bp_keep_drop: got %0b exp 0", rif.retire_keep); end
        tick();
        drive(1'b0, 0, 0, 0, 1'b1, 0, 1);
        checks++; if (sif.rsp_vld !== 1'b1) begin errors++; $display("FAIL bp_vld_3: got %0b exp 1", sif.rsp_vld); end
        checks++; if (sif.rsp_sid !== 4'd3) begin errors++; $display("FAIL bp_order_3: got %0d exp 3", sif.rsp_sid); end
        tick();
        checks++; if (sif.rsp_vld !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b exp 0", sif.rsp_vld); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL bp_idle: got %0b exp 1", idle); end
    endtask

    task automatic test_stability();
        sif.rsp_rdy = 1'b0;
        drive(1'b1, 6, 2, 11, 1'b0, 9, 3);
        tick();
        drive(1'b0, 0, 0, 0, 1'b1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            checks++; if (sif.rsp_vld !== 1'b1) begin errors++; $display("FAIL stab_vld[%0d]: got %0b exp 1", i, sif.rsp_vld); end
            checks++;
            if ({sif.rsp_sid, sif.rsp_rtype, sif.rsp_buf_id, sif.rsp_status, sif.rsp_err_code} !== {4'd6, 2'd2, 4'd11, 1'b0, 4'd9}) begin
                errors++;
                $display("FAIL stab_fields[%0d]: got sid=%0d rtype=%0d buf=%0d st=%0b ec=%0d exp 6/2/11/0/9",
                         i, sif.rsp_sid, sif.rsp_rtype, sif.rsp_buf_id, sif.rsp_status, sif.rsp_err_code);
            end
            tick();
        end
        sif.rsp_rdy = 1'b1;
        tick();
        checks++; if (err_cnt !== 4'd1) begin errors++; $display("FAIL stab_err_cnt: got %0d exp 1", err_cnt); end
        checks++; if (buf_rel_vld !== 1'b0) begin errors++; $display("FAIL stab_no_rel: got %0b exp 0", buf_rel_vld); end
        err_cnt_clr = 1'b1;
        tick();
        err_cnt_clr = 1'b0;
        checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL stab_clr: got %0d exp 0", err_cnt); end
    endtask

    task automatic test_release_filter();
        sif.rsp_rdy = 1'b1;
        drive(1'b1, 0, 0, 7, 1'b1, 0, 0);
        tick();
        checks++; if (buf_rel_vld !== 1'b0) begin errors++; $display("FAIL rel_pre: got %0b exp 0", buf_rel_vld); end
        drive(1'b1, 0, 0, 8, 1'b1, 0, 2);
        tick();
        checks++; if (buf_rel_vld !== 1'b1) begin errors++; $display("FAIL rel_7_vld: got %0b exp 1", buf_rel_vld); end
        checks++; if (buf_rel_id !== 4'd7) begin errors++; $display("FAIL rel_7_id: got %0d exp 7", buf_rel_id); end
        drive(1'b1, 0, 0, 9, 1'b1, 0, 0);
        tick();
        checks++; if (buf_rel_vld !== 1'b0) begin errors++; $display("FAIL rel_8_skip: got %0b exp 0", buf_rel_vld); end
        drive(1'b1, 0, 0, 10, 1'b1, 0, 1);
        tick();
        checks++; if (buf_rel_vld !== 1'b1) begin errors++; $display("FAIL rel_9_vld: got %0b exp 1", buf_rel_vld); end
        checks++; if (buf_rel_id !== 4'd9) begin errors++; $display("FAIL rel_9_id: got %0d exp 9", buf_rel_id); end
        drive(1'b0, 0, 0, 0, 1'b1, 0, 1);
        tick();
        checks++; if (buf_rel_vld !== 1'b0) begin errors++; $display("FAIL rel_10_skip: got %0b exp 0", buf_rel_vld); end
        tick();
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rel_idle: got %0b exp 1", idle); end
    endtask

    task automatic test_err_counter();
        sif.rsp_rdy = 1'b1;
        drive(1'b1, 4, 0, 1, 1'b0, 2, 1);
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 15) begin
                checks++; if (err_cnt !== 4'd14) begin errors++; $display("FAIL err_cnt_14: got %0d exp 14", err_cnt); end
            end
        end
        drive(1'b0, 0, 0, 0, 1'b1, 0, 1);
        tick();
        checks++; if (err_cnt !== 4'd15) begin errors++; $display("FAIL err_cnt_sat: got %0d exp 15", err_cnt); end
        checks++; if (sif.rsp_vld !== 1'b0) begin errors++; $display("FAIL err_drain: got %0b exp 0", sif.rsp_vld); end
        drive(1'b1, 4, 0, 1, 1'b0, 2, 1);
        tick();
        drive(1'b0, 0, 0, 0, 1'b1, 0, 1);
        checks++; if (sif.rsp_vld !== 1'b1) begin errors++; $display("FAIL err_clr_vld: got %0b exp 1", sif.rsp_vld); end
        err_cnt_clr = 1'b1;
        tick();
        err_cnt_clr = 1'b0;
        checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL err_clr_priority: got %0d exp 0", err_cnt); end
        checks++; if (sif.rsp_vld !== 1'b0) begin errors++; $display("FAIL err_clr_popped: got %0b exp 0", sif.rsp_vld); end
    endtask

    task automatic test_reset_mid();
        sif.rsp_rdy = 1'b1;
        drive(1'b1, 5, 0, 2, 1'b0, 1, 1);
        tick();
        drive(1'b0, 0, 0, 0, 1'b1, 0, 1);
        tick();
        checks++; if (err_cnt !== 4'd1) begin errors++; $display("FAIL mid_err_pre: got %0d exp 1", err_cnt); end
        sif.rsp_rdy = 1'b0;
        drive(1'b1, 1, 0, 12, 1'b1, 0, 0);
        tick();
        drive(1'b1, 2, 0, 13, 1'b1, 0, 0);
        tick();
        drive(1'b0, 0, 0, 0, 1'b1, 0, 1);
        checks++; if (rif.retire_keep !== 1'b1) begin errors++; $display("FAIL mid_full: got %0b exp 1", rif.retire_keep); end
        rstn = 1'b0;
        sif.rsp_rdy = 1'b1;
        #1;
        checks++; if (sif.rsp_vld !== 1'b0) begin errors++; $display("FAIL mid_async_vld: got %0b exp 0", sif.rsp_vld); end
        tick();
        checks++; if (rif.retire_keep !== 1'b0) begin errors++; $display("FAIL mid_keep: got %0b exp 0", rif.retire_keep); end
        checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL mid_err_cnt: got %0d exp 0", err_cnt); end
        checks++; if (buf_rel_vld !== 1'b0) begin errors++; $display("FAIL mid_rel_in_rst: got %0b exp 0", buf_rel_vld); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle: got %0b exp 1", idle); end
        rstn = 1'b1;
        tick();
        checks++; if (buf_rel_vld !== 1'b0) begin errors++; $display("FAIL mid_rel_after: got %0b exp 0", buf_rel_vld); end
        checks++; if (sif.rsp_vld !== 1'b0) begin errors++; $display("FAIL mid_vld_after: got %0b exp 0", sif.rsp_vld); end
        test_single();
    endtask

    initial begin
        rstn        = 1'b0;
        err_cnt_clr = 1'b0;
        sif.rsp_rdy = 1'b0;
        drive(1'b0, 0, 0, 0, 1'b1, 0, 1);
        test_reset();
        test_single();
        test_back_pressure();
        test_stability();
        test_release_filter();
        test_err_counter();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
